// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT constants, substitution/permutation layers and FSM encoding.
package present_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT       = 3'd1,
    ST_KEY_EXPAND = 3'd2,
    ST_ROUND      = 3'd3,
    ST_FINAL_XOR  = 3'd4,
    ST_DONE       = 3'd5
  } core_state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX[n];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
    return INV_SBOX[n];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = SBOX[s[4*i +: 4]];
    end
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = INV_SBOX[s[4*i +: 4]];
    end
    return r;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[(i * 16) % 63] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[i] = s[(i * 16) % 63];
    end
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// present_key_sched: PRESENT key register with forward and inverse key updates.
module present_key_sched
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 fwd_en,
  input  logic                 inv_en,
  input  logic [4:0]           counter,
  output logic [63:0]          round_key
);

  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] key_fwd, key_inv;

  if (KEY_WIDTH == 128) begin : g_k128
    logic [127:0] inv_t;
    // Forward: rotl 61, two S-boxes on the top byte, counter into [66:62].
    always_comb begin
      key_fwd          = {key_q[66:0], key_q[127:67]};
      key_fwd[127:124] = sbox4(key_fwd[127:124]);
      key_fwd[123:120] = sbox4(key_fwd[123:120]);
      key_fwd[66:62]   = key_fwd[66:62] ^ counter;
    end
    // Inverse: undo counter and S-boxes, then rotr 61.
    always_comb begin
      inv_t          = key_q;
      inv_t[66:62]   = key_q[66:62] ^ counter;
      inv_t[127:124] = inv_sbox4(key_q[127:124]);
      inv_t[123:120] = inv_sbox4(key_q[123:120]);
      key_inv        = {inv_t[60:0], inv_t[127:61]};
    end
  end else begin : g_k80
    logic [79:0] inv_t;
    // Forward: rotl 61, S-box on the top nibble, counter into [19:15].
    always_comb begin
      key_fwd        = {key_q[18:0], key_q[79:19]};
      key_fwd[79:76] = sbox4(key_fwd[79:76]);
      key_fwd[19:15] = key_fwd[19:15] ^ counter;
    end
    // Inverse: undo counter and S-box, then rotr 61.
    always_comb begin
      inv_t        = key_q;
      inv_t[19:15] = key_q[19:15] ^ counter;
      inv_t[79:76] = inv_sbox4(key_q[79:76]);
      key_inv      = {inv_t[60:0], inv_t[79:61]};
    end
  end

  // Next key: load has priority, then one update step per enabled cycle.
  always_comb begin
    key_d = key_q;
    if (load) begin
      key_d = key_in;
    end else if (fwd_en) begin
      key_d = key_fwd;
    end else if (inv_en) begin
      key_d = key_inv;
    end
  end

  // Key register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign round_key = key_q[KEY_WIDTH-1 -: 64];

endmodule

// File: rtl/present_core_param.sv
// present_core_param: iterative PRESENT cipher, one round per cycle, 80/128-bit key,
// encrypt or decrypt chosen per operation, start/busy/ready handshake.
module present_core_param
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80,
  parameter int unsigned ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [63:0]          data_out,
  output logic                 busy,
  output logic                 ready
);

  if ((KEY_WIDTH != 80) && (KEY_WIDTH != 128)) begin : g_bad_key_width
    $fatal(1, "present_core_param: KEY_WIDTH must be 80 or 128");
  end
  if ((ROUNDS < 1) || (ROUNDS > 31)) begin : g_bad_rounds
    $fatal(1, "present_core_param: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LastRound = 5'(ROUNDS);

  core_state_e fsm_q, fsm_d;
  logic [63:0] blk_q, blk_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [63:0] dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic        key_load, key_fwd_en, key_inv_en;
  logic [63:0] round_key;

  present_key_sched #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_key_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (key_load),
    .key_in   (key_in),
    .fwd_en   (key_fwd_en),
    .inv_en   (key_inv_en),
    .counter  (cnt_q),
    .round_key(round_key)
  );

  // Sequencing and datapath next-state. Block and key are captured straight into their
  // working registers at accept; INIT only primes the round counter.
  // Decrypt rounds run as state <= invS(invP(state ^ K_{i+1})) with the key register
  // stepping back K_{i+1} -> K_i, so the closing whitening with K_1 shares the
  // final XOR with encrypt.
  always_comb begin
    fsm_d      = fsm_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    dec_d      = dec_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    key_load   = 1'b0;
    key_fwd_en = 1'b0;
    key_inv_en = 1'b0;
    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (fsm_q == ST_DONE) begin
          fsm_d = ST_IDLE;
        end
        if (start) begin
          fsm_d    = ST_INIT;
          blk_d    = data_in;
          dec_d    = decrypt;
          key_load = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      ST_INIT: begin
        cnt_d = 5'd1;
        fsm_d = dec_q ? ST_KEY_EXPAND : ST_ROUND;
      end
      ST_KEY_EXPAND: begin
        key_fwd_en = 1'b1;
        if (cnt_q == LastRound) begin
          fsm_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_ROUND: begin
        if (!dec_q) begin
          blk_d      = p_layer(sbox_layer(blk_q ^ round_key));
          key_fwd_en = 1'b1;
          if (cnt_q == LastRound) begin
            fsm_d = ST_FINAL_XOR;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          blk_d      = inv_sbox_layer(inv_p_layer(blk_q ^ round_key));
          key_inv_en = 1'b1;
          if (cnt_q == 5'd1) begin
            fsm_d = ST_FINAL_XOR;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      ST_FINAL_XOR: begin
        // Key register holds K_{ROUNDS+1} after encrypt, K_1 after decrypt.
        dout_d  = blk_q ^ round_key;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        fsm_d   = ST_DONE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_present_core_param.sv
// tb_present_core_param: directed and random checks of present_core_param for 80- and
// 128-bit keys against a transaction-level PRESENT reference model.
module tb_present_core_param;

  localparam int EncLat = 33;
  localparam int DecLat = 64;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic        clk;
  logic        rst_n;
  logic [1:0]  start_s, dec_s, busy_s, ready_s;
  logic [63:0] din_s [2];
  logic [63:0] dout_s [2];
  logic [79:0]  key80_s;
  logic [127:0] key128_s;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state per instance (0 = 80-bit, 1 = 128-bit).
  bit [1:0]    m_busy = '0;
  bit [1:0]    m_ready = '0;
  int          m_left [2];
  logic [63:0] m_res  [2];
  logic [63:0] m_dout [2];

  present_core_param #(.KEY_WIDTH(80), .ROUNDS(31)) u_dut80 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s[0]),
    .decrypt (dec_s[0]),
    .data_in (din_s[0]),
    .key_in  (key80_s),
    .data_out(dout_s[0]),
    .busy    (busy_s[0]),
    .ready   (ready_s[0])
  );

  present_core_param #(.KEY_WIDTH(128), .ROUNDS(31)) u_dut128 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s[1]),
    .decrypt (dec_s[1]),
    .data_in (din_s[1]),
    .key_in  (key128_s),
    .data_out(dout_s[1]),
    .busy    (busy_s[1]),
    .ready   (ready_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] inv_sb(input logic [3:0] n);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      if (SB[j] == n) r = 4'(j);
    end
    return r;
  endfunction

  function automatic int perm_pos(input int j);
    return (j == 63) ? 63 : (j * 16) % 63;
  endfunction

  // Reference cipher: precompute K_1..K_32, then run the textbook rounds.
  function automatic logic [63:0] ref_cipher(input logic [63:0] din, input logic [127:0] key,
                                             input bit w128, input bit dec);
    logic [127:0] k;
    logic [79:0]  k80;
    logic [63:0]  rk [1:32];
    logic [63:0]  s, t;
    k   = key;
    k80 = key[79:0];
    for (int i = 1; i <= 32; i++) begin
      if (w128) begin
        rk[i] = k[127:64];
        k = (k << 61) | (k >> 67);
        k[127:124] = SB[k[127:124]];
        k[123:120] = SB[k[123:120]];
        k[66:62] = k[66:62] ^ 5'(i);
      end else begin
        rk[i] = k80[79:16];
        k80 = (k80 << 61) | (k80 >> 19);
        k80[79:76] = SB[k80[79:76]];
        k80[19:15] = k80[19:15] ^ 5'(i);
      end
    end
    if (!dec) begin
      s = din;
      for (int i = 1; i <= 31; i++) begin
        s = s ^ rk[i];
        for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
        t = '0;
        for (int j = 0; j < 64; j++) t[perm_pos(j)] = s[j];
        s = t;
      end
      s = s ^ rk[32];
    end else begin
      s = din ^ rk[32];
      for (int i = 31; i >= 1; i--) begin
        t = '0;
        for (int j = 0; j < 64; j++) t[j] = s[perm_pos(j)];
        for (int n = 0; n < 16; n++) t[4*n +: 4] = inv_sb(t[4*n +: 4]);
        s = t ^ rk[i];
      end
    end
    return s;
  endfunction

  // Transaction model: result and handshake timing from accept to ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        m_busy[g]  <= 1'b0;
        m_ready[g] <= 1'b0;
        m_left[g]  <= 0;
        m_res[g]   <= '0;
        m_dout[g]  <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (start_s[g] && !m_busy[g]) begin
          m_busy[g]  <= 1'b1;
          m_ready[g] <= 1'b0;
          m_left[g]  <= dec_s[g] ? DecLat : EncLat;
          m_res[g]   <= ref_cipher(din_s[g], (g == 0) ? {48'b0, key80_s} : key128_s,
                                   (g == 1), dec_s[g]);
        end else if (m_busy[g]) begin
          if (m_left[g] == 1) begin
            m_busy[g]  <= 1'b0;
            m_ready[g] <= 1'b1;
            m_dout[g]  <= m_res[g];
          end else begin
            m_left[g] <= m_left[g] - 1;
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      n_vec = n_vec + 3;
      if (busy_s[g] !== m_busy[g]) begin
        n_miss++;
        $display("FAIL cyc_busy[%0d] @%0t: got %b expected %b", g, $time, busy_s[g], m_busy[g]);
      end
      if (ready_s[g] !== m_ready[g]) begin
        n_miss++;
        $display("FAIL cyc_ready[%0d] @%0t: got %b expected %b", g, $time, ready_s[g],
                 m_ready[g]);
      end
      if (dout_s[g] !== m_dout[g]) begin
        n_miss++;
        $display("FAIL cyc_data_out[%0d] @%0t: got %h expected %h", g, $time, dout_s[g],
                 m_dout[g]);
      end
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input int g, input bit dec, input logic [63:0] din,
                          input logic [127:0] key);
    @(negedge clk);
    dec_s[g] = dec;
    din_s[g] = din;
    if (g == 0) key80_s = key[79:0];
    else key128_s = key;
    start_s[g] = 1'b1;
    @(posedge clk);
    #1 start_s[g] = 1'b0;
  endtask

  // Waits for ready; n0 is the number of edges already elapsed since accept.
  task automatic wait_done(input int g, input int n0, input int lat, input logic [63:0] exp,
                           input string name);
    int n;
    bit seen;
    n = n0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ready_s[g]) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no ready expected ready within 200 cycles", name);
    end else begin
      check64({name, "_latency"}, 64'(n), 64'(lat));
      check64({name, "_data"}, dout_s[g], exp);
    end
  endtask

  initial begin
    logic [63:0]  pt, ct;
    logic [127:0] key;
    rst_n    = 1'b0;
    start_s  = '0;
    dec_s    = '0;
    din_s[0] = '0;
    din_s[1] = '0;
    key80_s  = '0;
    key128_s = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check64("reset_busy", 64'(busy_s[g]), 64'd0);
      check64("reset_ready", 64'(ready_s[g]), 64'd0);
      check64("reset_data_out", dout_s[g], 64'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Pin the reference model to published vectors.
    check64("pin_enc80_zero", ref_cipher(64'd0, 128'd0, 1'b0, 1'b0), 64'h5579C1387B228445);
    check64("pin_enc80_ones", ref_cipher({64{1'b1}}, {48'd0, {80{1'b1}}}, 1'b0, 1'b0),
            64'h3333DCD3213210D2);
    check64("pin_dec80_ones", ref_cipher(64'hE72C46C0F5945049, {48'd0, {80{1'b1}}}, 1'b0, 1'b1),
            64'h0);
    check64("pin_enc128_zero", ref_cipher(64'd0, 128'd0, 1'b1, 1'b0), 64'h96DB702A2E6900AF);

    start_op(0, 1'b0, 64'd0, 128'd0);
    wait_done(0, 0, EncLat, 64'h5579C1387B228445, "enc80_zero");
    start_op(0, 1'b0, {64{1'b1}}, {128{1'b1}});
    wait_done(0, 0, EncLat, 64'h3333DCD3213210D2, "enc80_ones");
    start_op(0, 1'b1, 64'hE72C46C0F5945049, {128{1'b1}});
    wait_done(0, 0, DecLat, 64'h0, "dec80_ones");
    start_op(0, 1'b1, 64'hA112FFC72F68417B, 128'd0);
    wait_done(0, 0, DecLat, {64{1'b1}}, "dec80_zero");
    start_op(1, 1'b0, 64'd0, 128'd0);
    wait_done(1, 0, EncLat, 64'h96DB702A2E6900AF, "enc128_zero");
    start_op(1, 1'b1, 64'h96DB702A2E6900AF, 128'd0);
    wait_done(1, 0, DecLat, 64'h0, "dec128_zero");

    // start pulsed at T0+10 with different inputs must not disturb the running encrypt.
    start_op(0, 1'b0, 64'd0, 128'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    din_s[0]   = 64'h0123456789ABCDEF;
    key80_s    = 80'hDEADBEEFCAFEF00D1234;
    dec_s[0]   = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    check64("ignore_busy", 64'(busy_s[0]), 64'd1);
    wait_done(0, 10, EncLat, 64'h5579C1387B228445, "ignore_start");

    // Back-to-back: start during the cycle ready is high.
    start_op(0, 1'b0, {64{1'b1}}, {128{1'b1}});
    check64("b2b_ready_low", 64'(ready_s[0]), 64'd0);
    check64("b2b_busy_high", 64'(busy_s[0]), 64'd1);
    wait_done(0, 0, EncLat, 64'h3333DCD3213210D2, "b2b_second");

    // Asynchronous reset in the middle of round 15.
    start_op(0, 1'b0, 64'd0, 128'd0);
    repeat (15) @(posedge clk);
    #3;
    check64("midop_busy", 64'(busy_s[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check64("arst_busy", 64'(busy_s[0]), 64'd0);
    check64("arst_ready", 64'(ready_s[0]), 64'd0);
    check64("arst_data_out", dout_s[0], 64'd0);
    check64("arst_data_out128", dout_s[1], 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    start_op(0, 1'b0, {64{1'b1}}, {128{1'b1}});
    wait_done(0, 0, EncLat, 64'h3333DCD3213210D2, "restart");

    // Random round trips per key width.
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 200; r++) begin
        pt  = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        if (g == 0) key[127:80] = '0;
        start_op(g, 1'b0, pt, key);
        wait_done(g, 0, EncLat, ref_cipher(pt, key, (g == 1), 1'b0), "rnd_enc");
        ct = dout_s[g];
        start_op(g, 1'b1, ct, key);
        wait_done(g, 0, DecLat, pt, "rnd_dec");
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
